bfs_backtrack: RTL and testbench
================================

# bfs_backtrack

Backtrack stage of the BFS maze solver. The BFS controller raises `bt_en` once the distance-fill stage has finished. This block then walks the distance RAM from the goal cell back to the start cell, stepping each time to a neighbour whose distance is exactly one less. It streams the visited cells out over a valid/ready port. It reports completion to the controller through `bt_done`, and reports an unreachable goal or a corrupt map through `bt_no_path`.

## Interface
- `W`, default 16: grid width in cells.
- `H`, default 16: grid height in cells.
- `DW`, default 8: distance width. The all-ones value is `INF`, meaning unreached.
- `XW`/`YW`/`AW`: derived widths, `$clog2(W)`, `$clog2(H)` and `$clog2(W*H)`.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `bt_en` in 1: level enable from the BFS controller. A rising edge starts one walk.
- `start_x`/`start_y` in XW/YW: start cell. Sampled on the `bt_en` rising edge.
- `goal_x`/`goal_y` in XW/YW: goal cell. Sampled on the `bt_en` rising edge.
- `dist_rd_en` out 1: distance RAM read strobe.
- `dist_addr` out AW: RAM address, computed as y*W + x.
- `dist_rdata` in DW: RAM data, valid the cycle after `dist_rd_en`.
- `path_valid` out 1: a path beat is available.
- `path_rdy` in 1: downstream accepts the beat.
- `path_x`/`path_y` out XW/YW: cell carried by the beat. Beats are ordered goal first, start last.
- `path_last` out 1: the beat is the start cell.
- `path_len` out DW: step count, equal to dist[goal]. Valid while `bt_done` is high.
- `bt_done` out 1: one-cycle completion pulse.
- `bt_no_path` out 1: qualifies `bt_done`. It is 1 when the goal is unreachable or the map is inconsistent.

## Operation
- All outputs are 0 in reset.
- The state register and the `bt_en_q` edge register are asynchronously cleared by `rst_n` low.
- **IDLE**: on `bt_en && !bt_en_q`, latch the start and goal cells, set cur = goal, then go to RDG.
- **RDG**: assert `dist_rd_en` with addr(goal), then go to CHKG.
- **CHKG**:
  - If `dist_rdata` == `INF`, set no_path = 1 and go to DONE.
  - Otherwise set d = `dist_rdata`, `path_len` = `dist_rdata`, and go to EMIT.
- **EMIT**:
  - Drive `path_valid` with cur, and drive `path_last` = (cur == start).
  - Hold the beat until `path_valid && path_rdy`.
  - On handshake: if `path_last`, go to DONE with no_path = 0. Otherwise set dir = N and go to PRB.
- **PRB**: evaluate neighbour dir in the fixed order N(y-1), E(x+1), S(y+1), W(x-1).
  - If the neighbour is out of bounds, advance dir in the same cycle. Evaluation is combinational, so no read is issued.
  - If in bounds, assert `dist_rd_en` with addr(neighbour) and go to CHK.
  - If no directions remain, set no_path = 1 and go to DONE (corrupt map).
- **CHK**:
  - If `dist_rdata` == d-1, set cur = neighbour, d = d-1, and go to EMIT.
  - Otherwise advance dir and return to PRB.
- **DONE**: `bt_done` = 1 for exactly one cycle with `bt_no_path` = no_path, then go to IDLE.
- Only a new rising edge of `bt_en` re-arms the block. Holding `bt_en` high after DONE does nothing.
- Abort: `bt_en` low in any state other than IDLE or DONE forces IDLE on the next edge.
  - No `bt_done` pulse is produced.
  - `path_valid` drops, and any beat in flight is discarded.
- Arithmetic:
  - d is DW bits.
  - d-1 is evaluated only when d > 0.
  - A neighbour holding `INF` never matches.
  - d == 0 at a cell that is not start makes CHK always fail, which ends in the corrupt no-path result.
- Start == goal with dist 0: one beat with `path_last` = 1, then DONE with `path_len` = 0.

## Timing
- Let cycle E be the first cycle in which `bt_en` = 1 and `bt_en_q` = 0.
- The goal read strobe is asserted in E+1; data is checked in E+2.
- Unreachable goal: `bt_done` = `bt_no_path` = 1 in E+3, with no beats emitted.
- First beat: `path_valid` rises in E+3.
- Per step with zero backpressure: 1 EMIT cycle plus 2 cycles per in-bounds probe. That is 3 cycles minimum and 9 maximum.
- `bt_done` rises the cycle after the last handshake.
- `path_*` outputs are registered and stay stable while `path_valid && !path_rdy`.
- At most one RAM read is outstanding; `dist_rd_en` is never asserted on two consecutive cycles.

## Test plan
- **Straight line**:
  - Setup: W=H=4, start (0,0), goal (3,0), row 0 dist = 0,1,2,3, all other cells `INF`, `path_rdy`=1.
  - Expected: beats (3,0),(2,0),(1,0),(0,0), with `path_last` only on the 4th beat.
  - Expected: then `bt_done`=1, `bt_no_path`=0, `path_len`=3.
- **Unreachable**:
  - Setup: dist[goal] = 0xFF.
  - Expected: no `path_valid`, and `bt_done`=`bt_no_path`=1 exactly in E+3 for one cycle.
- **Tie-break**:
  - Setup: cur (1,1) with d=2; both (1,0) and (2,1) hold 1.
  - Expected: the next beat is (1,0), because N wins.
  - Expected: the read addresses seen are 5 then 1 only.
- **Backpressure**:
  - Setup: hold `path_rdy`=0 for 5 cycles on the second beat.
  - Expected: `path_x`/`path_y`/`path_last` stay constant throughout.
  - Expected: no `dist_rd_en` during the stall, and the beat sequence is unchanged afterwards.
- **Start == goal (2,2)** with dist 0: one beat (2,2) with `path_last`=1, then `bt_done` with `path_len`=0.
- **Abort and reset**:
  - Drop `bt_en` mid-walk: block returns to IDLE, no `bt_done`; a new rising edge restarts the walk from the goal.
  - Assert `rst_n`=0 asynchronously mid-EMIT: all outputs go to 0 immediately.

Source files
------------

// File: rtl/bfs_backtrack_if.sv
// Stream and RAM-port bundle for the BFS backtrack stage.
// The master side reads the distance RAM and produces path beats;
// the slave side is the distance RAM plus the path consumer.
interface bfs_backtrack_if #(
   parameter int W  = 16,
   parameter int H  = 16,
   parameter int DW = 8
);
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);
   localparam int AW = $clog2(W * H);

   // distance RAM read port (registered read, one cycle latency)
   logic          dist_rd_en;
   logic [AW-1:0] dist_addr;
   logic [DW-1:0] dist_rdata;

   // path beat stream, goal first, start last
   logic          path_valid;
   logic          path_rdy;
   logic [XW-1:0] path_x;
   logic [YW-1:0] path_y;
   logic          path_last;

   modport master (
      output dist_rd_en, dist_addr,
      input  dist_rdata,
      output path_valid, path_x, path_y, path_last,
      input  path_rdy
   );

   modport slave (
      input  dist_rd_en, dist_addr,
      output dist_rdata,
      input  path_valid, path_x, path_y, path_last,
      output path_rdy
   );
endinterface

// File: rtl/bfs_backtrack.sv
// Backtrack stage of the BFS maze solver: walks the distance RAM from
// the goal back to the start, always stepping to a neighbour whose
// distance is exactly one less, and streams each visited cell out.
module bfs_backtrack #(
   parameter  int W  = 16,
   parameter  int H  = 16,
   parameter  int DW = 8,
   localparam int XW = $clog2(W),
   localparam int YW = $clog2(H),
   localparam int AW = $clog2(W * H)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           bt_en,
   input  logic [XW-1:0]  start_x,
   input  logic [YW-1:0]  start_y,
   input  logic [XW-1:0]  goal_x,
   input  logic [YW-1:0]  goal_y,
   bfs_backtrack_if.master bus,
   output logic [DW-1:0]  path_len,
   output logic           bt_done,
   output logic           bt_no_path
);

   localparam logic [DW-1:0] INF = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RDG,
      S_CHKG,
      S_EMIT,
      S_PRB,
      S_CHK,
      S_DONE
   } state_t;

   state_t        state_q,      state_d;
   logic          bt_en_q;
   logic [XW-1:0] start_x_q,    start_x_d;
   logic [YW-1:0] start_y_q,    start_y_d;
   logic [XW-1:0] goal_x_q,     goal_x_d;
   logic [YW-1:0] goal_y_q,     goal_y_d;
   logic [XW-1:0] cur_x_q,      cur_x_d;
   logic [YW-1:0] cur_y_q,      cur_y_d;
   logic [DW-1:0] d_q,          d_d;
   // 0..3 = N,E,S,W; 4 means every direction has been tried
   logic [2:0]    dir_q,        dir_d;
   logic          path_valid_q, path_valid_d;
   logic [XW-1:0] path_x_q,     path_x_d;
   logic [YW-1:0] path_y_q,     path_y_d;
   logic          path_last_q,  path_last_d;
   logic [DW-1:0] path_len_q,   path_len_d;
   logic          bt_done_q,    bt_done_d;
   logic          bt_no_path_q, bt_no_path_d;

   // neighbour candidates of the current cell, indexed by direction
   logic          nb_ok [4];
   logic [XW-1:0] nb_x  [4];
   logic [YW-1:0] nb_y  [4];

   logic          probe_found;
   logic [1:0]    probe_dir;
   logic [1:0]    chk_dir;
   logic          chk_match;
   logic          rd_en;
   logic [AW-1:0] rd_addr;

   function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x,
                                             input logic [YW-1:0] y);
      return AW'(32'(y) * 32'(W) + 32'(x));
   endfunction

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_nb
         if (gi == 0) begin : g_north
            assign nb_ok[gi] = (cur_y_q != '0);
            assign nb_x[gi]  = cur_x_q;
            assign nb_y[gi]  = cur_y_q - YW'(1);
         end else if (gi == 1) begin : g_east
            assign nb_ok[gi] = (32'(cur_x_q) < 32'(W - 1));
            assign nb_x[gi]  = cur_x_q + XW'(1);
            assign nb_y[gi]  = cur_y_q;
         end else if (gi == 2) begin : g_south
            assign nb_ok[gi] = (32'(cur_y_q) < 32'(H - 1));
            assign nb_x[gi]  = cur_x_q;
            assign nb_y[gi]  = cur_y_q + YW'(1);
         end else begin : g_west
            assign nb_ok[gi] = (cur_x_q != '0);
            assign nb_x[gi]  = cur_x_q - XW'(1);
            assign nb_y[gi]  = cur_y_q;
         end
      end
   endgenerate

   // first in-bounds direction at or after dir_q; out-of-bounds ones are skipped in the same cycle
   always_comb begin
      probe_found = 1'b0;
      probe_dir   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (i >= int'(dir_q) && nb_ok[i]) begin
            probe_found = 1'b1;
            probe_dir   = 2'(i);
         end
      end
   end

   // neighbour under test in CHK; a zero distance or INF can never be the predecessor
   always_comb begin
      chk_dir   = dir_q[1:0];
      chk_match = (d_q != '0) && (bus.dist_rdata != INF) &&
                  (bus.dist_rdata == d_q - DW'(1));
   end

   // RAM strobe decoded from the registered state: RDG and PRB are the only
   // read states and are never adjacent, so reads never issue back to back
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      if (state_q == S_RDG) begin
         rd_en   = 1'b1;
         rd_addr = addr_of(goal_x_q, goal_y_q);
      end else if (state_q == S_PRB && probe_found) begin
         rd_en   = 1'b1;
         rd_addr = addr_of(nb_x[probe_dir], nb_y[probe_dir]);
      end
   end

   // walk control: next state and next values of every registered output
   always_comb begin
      state_d      = state_q;
      start_x_d    = start_x_q;
      start_y_d    = start_y_q;
      goal_x_d     = goal_x_q;
      goal_y_d     = goal_y_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      d_d          = d_q;
      dir_d        = dir_q;
      path_valid_d = path_valid_q;
      path_x_d     = path_x_q;
      path_y_d     = path_y_q;
      path_last_d  = path_last_q;
      path_len_d   = path_len_q;
      bt_done_d    = 1'b0;
      bt_no_path_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bt_en && !bt_en_q) begin
               start_x_d = start_x;
               start_y_d = start_y;
               goal_x_d  = goal_x;
               goal_y_d  = goal_y;
               cur_x_d   = goal_x;
               cur_y_d   = goal_y;
               state_d   = S_RDG;
            end
         end
         S_RDG: begin
            state_d = S_CHKG;
         end
         S_CHKG: begin
            if (bus.dist_rdata == INF) begin
               bt_done_d    = 1'b1;
               bt_no_path_d = 1'b1;
               state_d      = S_DONE;
            end else begin
               d_d          = bus.dist_rdata;
               path_len_d   = bus.dist_rdata;
               path_valid_d = 1'b1;
               path_x_d     = cur_x_q;
               path_y_d     = cur_y_q;
               path_last_d  = (cur_x_q == start_x_q) && (cur_y_q == start_y_q);
               state_d      = S_EMIT;
            end
         end
         S_EMIT: begin
            if (bus.path_rdy) begin
               path_valid_d = 1'b0;
               if (path_last_q) begin
                  bt_done_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  dir_d   = 3'd0;
                  state_d = S_PRB;
               end
            end
         end
         S_PRB: begin
            if (probe_found) begin
               dir_d   = {1'b0, probe_dir};
               state_d = S_CHK;
            end else begin
               // no neighbour one step closer: the map is inconsistent
               bt_done_d    = 1'b1;
               bt_no_path_d = 1'b1;
               state_d      = S_DONE;
            end
         end
         S_CHK: begin
            if (chk_match) begin
               cur_x_d      = nb_x[chk_dir];
               cur_y_d      = nb_y[chk_dir];
               d_d          = d_q - DW'(1);
               path_valid_d = 1'b1;
               path_x_d     = nb_x[chk_dir];
               path_y_d     = nb_y[chk_dir];
               path_last_d  = (nb_x[chk_dir] == start_x_q) && (nb_y[chk_dir] == start_y_q);
               state_d      = S_EMIT;
            end else begin
               dir_d   = dir_q + 3'd1;
               state_d = S_PRB;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // dropping the enable mid-walk abandons it silently, discarding any pending beat
      if (!bt_en && state_q != S_IDLE && state_q != S_DONE) begin
         state_d      = S_IDLE;
         path_valid_d = 1'b0;
         bt_done_d    = 1'b0;
         bt_no_path_d = 1'b0;
      end
   end

   // state and output registers, cleared asynchronously so outputs drop the moment reset asserts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         bt_en_q      <= 1'b0;
         start_x_q    <= '0;
         start_y_q    <= '0;
         goal_x_q     <= '0;
         goal_y_q     <= '0;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         d_q          <= '0;
         dir_q        <= '0;
         path_valid_q <= 1'b0;
         path_x_q     <= '0;
         path_y_q     <= '0;
         path_last_q  <= 1'b0;
         path_len_q   <= '0;
         bt_done_q    <= 1'b0;
         bt_no_path_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bt_en_q      <= bt_en;
         start_x_q    <= start_x_d;
         start_y_q    <= start_y_d;
         goal_x_q     <= goal_x_d;
         goal_y_q     <= goal_y_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         d_q          <= d_d;
         dir_q        <= dir_d;
         path_valid_q <= path_valid_d;
         path_x_q     <= path_x_d;
         path_y_q     <= path_y_d;
         path_last_q  <= path_last_d;
         path_len_q   <= path_len_d;
         bt_done_q    <= bt_done_d;
         bt_no_path_q <= bt_no_path_d;
      end
   end

   assign bus.dist_rd_en = rd_en;
   assign bus.dist_addr  = rd_addr;
   assign bus.path_valid = path_valid_q;
   assign bus.path_x     = path_x_q;
   assign bus.path_y     = path_y_q;
   assign bus.path_last  = path_last_q;
   assign path_len       = path_len_q;
   assign bt_done        = bt_done_q;
   assign bt_no_path     = bt_no_path_q;

endmodule

// File: tb/tb_bfs_backtrack.sv
// Directed bench for bfs_backtrack on a 4x4 grid with a behavioural distance RAM.
module tb_bfs_backtrack;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bt_en;
   logic [1:0] start_x, start_y, goal_x, goal_y;
   logic [7:0] path_len;
   logic       bt_done, bt_no_path;

   bfs_backtrack_if #(.W(W), .H(H), .DW(DW)) bus_if ();

   bfs_backtrack #(.W(W), .H(H), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bt_en     (bt_en),
      .start_x   (start_x),
      .start_y   (start_y),
      .goal_x    (goal_x),
      .goal_y    (goal_y),
      .bus       (bus_if),
      .path_len  (path_len),
      .bt_done   (bt_done),
      .bt_no_path(bt_no_path)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] mem [16];
   int         rd_log [$];
   int         rd_b2b = 0;
   logic       rd_prev = 1'b0;
   logic [4:0] beats [$];
   int         beat_rds [$];
   bit         done_seen;
   logic       np_seen;
   logic [7:0] len_seen;
   int         stall_chg, stall_rd, stall_seen;
   int         done_cnt;

   // distance RAM: registered read, logs every address and back-to-back strobes
   always @(posedge clk) begin
      if (bus_if.dist_rd_en) begin
         bus_if.dist_rdata <= mem[bus_if.dist_addr];
         rd_log.push_back(int'(bus_if.dist_addr));
         if (rd_prev) rd_b2b <= rd_b2b + 1;
      end
      rd_prev <= bus_if.dist_rd_en;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] bt(input int x, input int y, input bit last);
      return {last, 2'(x), 2'(y)};
   endfunction

   function automatic logic [20:0] all_outs();
      return {bus_if.path_valid, bus_if.path_x, bus_if.path_y, bus_if.path_last,
              bus_if.dist_rd_en, bus_if.dist_addr, path_len, bt_done, bt_no_path};
   endfunction

   task automatic mem_clear();
      for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
   endtask

   task automatic mem_line();
      mem_clear();
      for (int i = 0; i < 4; i++) mem[i] = 8'(i);
   endtask

   // one full walk; optionally stalls the beat with index stall_beat for stall_len cycles
   task automatic walk(input int sx, input int sy, input int gx, input int gy,
                       input int stall_beat, input int stall_len);
      logic [4:0] snap;
      logic [4:0] now;
      int         left;
      beats.delete();
      beat_rds.delete();
      rd_log.delete();
      done_seen  = 0;
      np_seen    = 1'b0;
      len_seen   = '0;
      stall_chg  = 0;
      stall_rd   = 0;
      stall_seen = 0;
      left       = stall_len;
      snap       = '0;
      start_x = 2'(sx); start_y = 2'(sy);
      goal_x  = 2'(gx); goal_y  = 2'(gy);
      bus_if.path_rdy = 1'b1;
      bt_en = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         bus_if.path_rdy = 1'b1;
         now = {bus_if.path_last, bus_if.path_x, bus_if.path_y};
         if (bus_if.path_valid && beats.size() == stall_beat && left > 0) begin
            bus_if.path_rdy = 1'b0;
            if (left == stall_len) snap = now;
            else if (now !== snap) stall_chg++;
            if (bus_if.dist_rd_en) stall_rd++;
            stall_seen++;
            left--;
         end
         if (bus_if.path_valid && bus_if.path_rdy) begin
            beats.push_back(now);
            beat_rds.push_back(rd_log.size());
         end
         if (bt_done) begin
            done_seen = 1;
            np_seen   = bt_no_path;
            len_seen  = path_len;
            break;
         end
      end
      check("walk_done_seen", 32'(done_seen), 32'd1);
      @(negedge clk);
      check("done_pulse_one_cycle", 32'(bt_done), 32'd0);
      bt_en = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      bt_en = 1'b0;
      start_x = '0; start_y = '0; goal_x = '0; goal_y = '0;
      bus_if.path_rdy = 1'b1;
      mem_clear();
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'(all_outs()), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_outputs", 32'(all_outs()), 32'd0);

      // straight line along row 0
      mem_line();
      walk(0, 0, 3, 0, -1, 0);
      check("line_beats", 32'(beats.size()), 32'd4);
      if (beats.size() == 4) begin
         check("line_b0", 32'(beats[0]), 32'(bt(3, 0, 0)));
         check("line_b1", 32'(beats[1]), 32'(bt(2, 0, 0)));
         check("line_b2", 32'(beats[2]), 32'(bt(1, 0, 0)));
         check("line_b3", 32'(beats[3]), 32'(bt(0, 0, 1)));
      end
      check("line_no_path", 32'(np_seen), 32'd0);
      check("line_len", 32'(len_seen), 32'd3);
      check("line_first_read", (rd_log.size() > 0) ? 32'(rd_log[0]) : 32'hDEAD, 32'd3);

      // unreachable goal: cycle-exact pulse at E+3
      mem_clear();
      start_x = 2'd0; start_y = 2'd0; goal_x = 2'd3; goal_y = 2'd3;
      bt_en = 1'b1;
      @(negedge clk);
      check("unr_rd_en_e1", 32'(bus_if.dist_rd_en), 32'd1);
      check("unr_addr_e1", 32'(bus_if.dist_addr), 32'd15);
      @(negedge clk);
      check("unr_e2", 32'({bt_done, bus_if.dist_rd_en, bus_if.path_valid}), 32'd0);
      @(negedge clk);
      check("unr_done_e3", 32'({bt_done, bt_no_path, bus_if.path_valid}), 32'b110);
      @(negedge clk);
      check("unr_e4", 32'({bt_done, bt_no_path, bus_if.path_valid}), 32'd0);
      bt_en = 1'b0;
      @(negedge clk);

      // tie-break: (1,0) and (2,1) both hold 1 around (1,1); north wins
      mem_clear();
      mem[0] = 8'd0; mem[1] = 8'd1; mem[4] = 8'd1; mem[6] = 8'd1; mem[5] = 8'd2;
      walk(0, 0, 1, 1, -1, 0);
      check("tie_beats", 32'(beats.size()), 32'd3);
      if (beats.size() == 3) begin
         check("tie_b1_north", 32'(beats[1]), 32'(bt(1, 0, 0)));
         check("tie_reads_before_b1", 32'(beat_rds[1]), 32'd2);
         check("tie_b2", 32'(beats[2]), 32'(bt(0, 0, 1)));
      end
      if (rd_log.size() >= 2) begin
         check("tie_rd0", 32'(rd_log[0]), 32'd5);
         check("tie_rd1", 32'(rd_log[1]), 32'd1);
      end else begin
         check("tie_rd_count", 32'(rd_log.size()), 32'd5);
      end
      check("tie_len", 32'(len_seen), 32'd2);

      // backpressure on the second beat
      mem_line();
      walk(0, 0, 3, 0, 1, 5);
      check("bp_stall_cycles", 32'(stall_seen), 32'd5);
      check("bp_beat_stable", 32'(stall_chg), 32'd0);
      check("bp_no_read", 32'(stall_rd), 32'd0);
      check("bp_beats", 32'(beats.size()), 32'd4);
      if (beats.size() == 4) begin
         check("bp_b1", 32'(beats[1]), 32'(bt(2, 0, 0)));
         check("bp_b3", 32'(beats[3]), 32'(bt(0, 0, 1)));
      end
      check("bp_len", 32'(len_seen), 32'd3);

      // start == goal
      mem_clear();
      mem[10] = 8'd0;
      walk(2, 2, 2, 2, -1, 0);
      check("same_beats", 32'(beats.size()), 32'd1);
      if (beats.size() == 1) check("same_b0", 32'(beats[0]), 32'(bt(2, 2, 1)));
      check("same_len", 32'(len_seen), 32'd0);
      check("same_no_path", 32'(np_seen), 32'd0);

      // corrupt map: distance 0 at a cell that is not the start
      mem_clear();
      mem[0] = 8'd0; mem[1] = 8'd0;
      walk(0, 0, 1, 0, -1, 0);
      check("bad_beats", 32'(beats.size()), 32'd1);
      check("bad_no_path", 32'(np_seen), 32'd1);
      check("bad_reads", 32'(rd_log.size()), 32'd4);

      // abort mid-walk, then restart
      mem_line();
      start_x = 2'd0; start_y = 2'd0; goal_x = 2'd3; goal_y = 2'd0;
      bt_en = 1'b1;
      repeat (5) @(negedge clk);
      bt_en = 1'b0;
      @(negedge clk);
      check("abort_valid_low", 32'(bus_if.path_valid), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bt_done || bus_if.path_valid || bus_if.dist_rd_en) done_cnt++;
      end
      check("abort_quiet", 32'(done_cnt), 32'd0);
      walk(0, 0, 3, 0, -1, 0);
      check("restart_beats", 32'(beats.size()), 32'd4);
      if (beats.size() == 4) check("restart_b0", 32'(beats[0]), 32'(bt(3, 0, 0)));
      check("restart_rd0", (rd_log.size() > 0) ? 32'(rd_log[0]) : 32'hDEAD, 32'd3);

      // asynchronous reset while a beat is stalled in EMIT
      mem_line();
      start_x = 2'd0; start_y = 2'd0; goal_x = 2'd3; goal_y = 2'd0;
      bus_if.path_rdy = 1'b0;
      bt_en = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_pre_valid", 32'({bus_if.path_valid, bus_if.path_x, path_len}), 32'({1'b1, 2'd3, 8'd3}));
      #2 rst_n = 1'b0;
      #1 check("rst_async_outputs", 32'(all_outs()), 32'd0);
      @(negedge clk);
      bt_en = 1'b0;
      rst_n = 1'b1;
      bus_if.path_rdy = 1'b1;
      @(negedge clk);

      check("no_b2b_reads", 32'(rd_b2b), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
